// File: rtl/generic_matrix_multiply_unit.sv
// generic_matrix_multiply_unit: sequential signed C = A x B, one MAC per clock, start/busy/done handshake.
module generic_matrix_multiply_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 32,
  parameter int M_DIM       = 2,
  parameter int K_DIM       = 3,
  parameter int N_DIM       = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          op_start_mm,
  input  logic signed [DATA_WIDTH-1:0]  matrix_a_in [0:M_DIM-1][0:K_DIM-1],
  input  logic signed [DATA_WIDTH-1:0]  matrix_b_in [0:K_DIM-1][0:N_DIM-1],
  output logic signed [ACCUM_WIDTH-1:0] output_matrix_c_out [0:M_DIM-1][0:N_DIM-1],
  output logic                          op_busy_mm,
  output logic                          op_done_mm
);
  localparam int MW = M_DIM > 1 ? $clog2(M_DIM) : 1;
  localparam int NW = N_DIM > 1 ? $clog2(N_DIM) : 1;
  localparam int KW = K_DIM > 1 ? $clog2(K_DIM) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;
  logic [MW-1:0] m;
  logic [NW-1:0] n;
  logic [KW-1:0] k;
  logic signed [DATA_WIDTH-1:0] a_q [0:M_DIM-1][0:K_DIM-1];
  logic signed [DATA_WIDTH-1:0] b_q [0:K_DIM-1][0:N_DIM-1];
  logic signed [ACCUM_WIDTH-1:0] acc, acc_next;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic last_k, last_n, last_m;
  assign last_k = k == KW'(K_DIM - 1);
  assign last_n = n == NW'(N_DIM - 1);
  assign last_m = m == MW'(M_DIM - 1);
  assign prod = a_q[m][k] * b_q[k][n];
  assign acc_next = acc + ACCUM_WIDTH'(prod);
  assign op_busy_mm = state == CALC;
  assign op_done_mm = state == DONE;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = op_start_mm ? CALC : IDLE;
      CALC:    state_next = (last_k && last_n && last_m) ? DONE : CALC;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      m <= '0;
      n <= '0;
      k <= '0;
      acc <= '0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      output_matrix_c_out <= '{default: '0};
    end else begin
      state <= state_next;
      if (state == IDLE && op_start_mm) begin
        a_q <= matrix_a_in;
        b_q <= matrix_b_in;
        m <= '0;
        n <= '0;
        k <= '0;
        acc <= '0;
      end else if (state == CALC) begin
        // k innermost, then n, then m; an element commits on its last reduction step
        acc <= last_k ? '0 : acc_next;
        k <= last_k ? '0 : k + 1'b1;
        if (last_k) begin
          output_matrix_c_out[m][n] <= acc_next;
          n <= last_n ? '0 : n + 1'b1;
          if (last_n) m <= last_m ? '0 : m + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_generic_matrix_multiply_unit.sv
// tb_generic_matrix_multiply_unit: directed table vectors plus hand-written corner sequences.
module tb_generic_matrix_multiply_unit;
  logic clk_tb = 1'b0;
  logic rst_n;
  logic op_start_mm;
  logic signed [7:0]  matrix_a_in [0:1][0:2];
  logic signed [7:0]  matrix_b_in [0:2][0:1];
  logic signed [31:0] output_matrix_c_out [0:1][0:1];
  logic op_busy_mm, op_done_mm;
  int applied = 0;
  int miscompares = 0;
  typedef struct {
    int a [0:1][0:2];
    int b [0:2][0:1];
    int c [0:1][0:1];
  } vec_t;
  vec_t vecs [0:4];

  generic_matrix_multiply_unit dut (
    .clk(clk_tb),
    .rst_n(rst_n),
    .op_start_mm(op_start_mm),
    .matrix_a_in(matrix_a_in),
    .matrix_b_in(matrix_b_in),
    .output_matrix_c_out(output_matrix_c_out),
    .op_busy_mm(op_busy_mm),
    .op_done_mm(op_done_mm)
  );

  always #5 clk_tb = ~clk_tb;

  task automatic check(input string name, input longint act, input longint exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int idx);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++) begin
        matrix_a_in[i][j] = 8'(vecs[idx].a[i][j]);
        matrix_b_in[j][i] = 8'(vecs[idx].b[j][i]);
      end
  endtask

  task automatic check_c(input string name, input int idx);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        check($sformatf("%s_c%0d%0d", name, i, j), longint'(output_matrix_c_out[i][j]), longint'(vecs[idx].c[i][j]));
  endtask

  // Called at a negedge; returns at the negedge of the cycle after DONE so a follow-up call is back-to-back.
  task automatic run_op(input int idx, input bit disturb, input int prev);
    int cyc;
    drive(idx);
    op_start_mm = 1'b1;
    @(negedge clk_tb);
    op_start_mm = 1'b0;
    cyc = 1;
    check("busy_cycle1", longint'(op_busy_mm), 1);
    if (prev >= 0) check_c("hold_cycle1", prev);
    while (!op_done_mm && cyc < 40) begin
      @(negedge clk_tb);
      cyc++;
      if (disturb && cyc == 5) begin
        drive(3);
        op_start_mm = 1'b1;
      end
      if (disturb && cyc == 8) op_start_mm = 1'b0;
      if (prev >= 0 && cyc == 6)
        check("hold_c11_cycle6", longint'(output_matrix_c_out[1][1]), longint'(vecs[prev].c[1][1]));
      if (cyc < 13) check("busy_in_calc", longint'(op_busy_mm), 1);
    end
    check("done_cycle", longint'(cyc), 13);
    check("busy_at_done", longint'(op_busy_mm), 0);
    check_c($sformatf("vec%0d_done", idx), idx);
    @(negedge clk_tb);
    check("done_one_cycle", longint'(op_done_mm), 0);
    check("busy_after_done", longint'(op_busy_mm), 0);
    check_c($sformatf("vec%0d_stable", idx), idx);
  endtask

  initial begin
    vecs[0] = '{'{'{1, 2, 3}, '{4, 5, 6}}, '{'{7, 8}, '{9, 1}, '{2, 3}}, '{'{31, 19}, '{85, 55}}};
    vecs[1] = '{'{'{-1, 2, -3}, '{4, -5, 6}}, '{'{7, 8}, '{9, 1}, '{2, 3}}, '{'{5, -15}, '{-5, 45}}};
    vecs[2] = '{'{'{-128, -128, -128}, '{-128, -128, -128}}, '{'{-128, -128}, '{-128, -128}, '{-128, -128}},
                '{'{49152, 49152}, '{49152, 49152}}};
    vecs[3] = '{'{'{127, 127, 127}, '{127, 127, 127}}, '{'{127, 127}, '{127, 127}, '{127, 127}},
                '{'{48387, 48387}, '{48387, 48387}}};
    vecs[4] = '{'{'{1, 2, 3}, '{4, 5, 6}}, '{'{1, 0}, '{0, 1}, '{0, 0}}, '{'{1, 2}, '{4, 5}}};
    rst_n = 1'b0;
    op_start_mm = 1'b0;
    drive(0);
    repeat (2) @(negedge clk_tb);
    check("reset_busy", longint'(op_busy_mm), 0);
    check("reset_done", longint'(op_done_mm), 0);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        check("reset_c", longint'(output_matrix_c_out[i][j]), 0);
    rst_n = 1'b1;
    @(negedge clk_tb);
    for (int v = 0; v < 4; v++) run_op(v, 1'b0, -1);
    run_op(0, 1'b1, -1);
    run_op(4, 1'b0, 0);
    @(negedge clk_tb);
    drive(1);
    op_start_mm = 1'b1;
    @(negedge clk_tb);
    op_start_mm = 1'b0;
    repeat (5) @(negedge clk_tb);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", longint'(op_busy_mm), 0);
    check("midreset_done", longint'(op_done_mm), 0);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        check("midreset_c", longint'(output_matrix_c_out[i][j]), 0);
    @(negedge clk_tb);
    rst_n = 1'b1;
    run_op(1, 1'b0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
